inst_prefetcher: RTL and testbench

Instruction fetch unit feeding the instruction decoder: issues 16-bit read requests to the TX interface at the fetch PC, collects the serial read data from RX, and presents instruction words on the decoder's `inst_valid`/`inst`/`inst_done` handshake. Also supplies imm16 operands serially, owns the architectural next-PC, serializes it to the scheduler, and accepts jump targets from it.

---
 rtl/inst_prefetcher.sv | 179 +++++++++++++++++
 tb/tb_inst_prefetcher.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetcher.sv
// rtl/inst_prefetcher.sv - instruction fetch, imm16 supply and next-PC ownership for the decoder
module inst_prefetcher #(
   parameter int                      REG_BITS = 8,
   parameter int                      NSHIFT   = 2,
   parameter logic [2*REG_BITS-1:0]   RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic                       inst_valid,
   output logic [2*REG_BITS-1:0]      inst,
   input  logic                       inst_done,
   input  logic                       load_imm16,
   output logic                       imm16_loaded,
   output logic [NSHIFT-1:0]          imm_data_out,
   input  logic                       next_imm_data,
   input  logic                       block_prefetch,
   input  logic                       reserve_tx,
   input  logic                       write_pc,
   input  logic [NSHIFT-1:0]          pc_data_in,
   input  logic                       ext_pc_next,
   output logic [NSHIFT-1:0]          pc_data_out,
   output logic                       prefetch_idle,
   output logic                       tx_command_valid,
   output logic [2*REG_BITS-1:0]      tx_addr,
   input  logic                       tx_command_started,
   input  logic                       rx_data_valid,
   input  logic [NSHIFT-1:0]          rx_pins
);

   localparam int W     = 2 * REG_BITS;
   localparam int BEATS = W / NSHIFT;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [W-1:0]  WORD_STEP = W'(2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RECV
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [W-1:0]      fetch_pc;
   logic [W-1:0]      next_pc;
   logic [W-1:0]      word_buf;
   logic              buf_valid;
   logic [W-1:0]      inst_q;
   logic              inst_valid_q;
   logic [W-1:0]      tx_addr_q;
   logic [CW-1:0]     beat_cnt;
   logic [CW-1:0]     imm_cnt;
   logic              discard;

   logic              start_req;
   logic              accept;
   logic              withdraw;
   logic              rx_beat;
   logic              last_beat;
   logic              imm_step;
   logic              imm_last;
   logic              transfer;
   logic              pc_inc;

   // A new read goes out only when the one-word buffer is empty and nobody else wants TX or the PC.
   assign start_req = (state_q == S_IDLE) & ~buf_valid & ~block_prefetch & ~reserve_tx & ~write_pc;
   assign accept    = (state_q == S_REQ) & tx_command_started;
   assign withdraw  = (state_q == S_REQ) & ~tx_command_started & (block_prefetch | write_pc);
   assign rx_beat   = (state_q == S_RECV) & rx_data_valid;
   assign last_beat = rx_beat & (beat_cnt == LAST_BEAT);

   // An imm chunk is consumed only while the decoder actually sees a loaded word; a jump cancels it.
   assign imm16_loaded = load_imm16 & buf_valid;
   assign imm_step     = next_imm_data & imm16_loaded & ~write_pc;
   assign imm_last     = imm_step & (imm_cnt == LAST_BEAT);

   // A jump invalidates the buffered word, so it must not slip into the instruction slot that cycle.
   assign transfer = buf_valid & ~load_imm16 & (~inst_valid_q | inst_done) & ~write_pc;
   assign pc_inc   = transfer | imm_last;

   assign inst_valid       = inst_valid_q;
   assign inst             = inst_q;
   assign imm_data_out     = word_buf[NSHIFT-1:0];
   assign pc_data_out      = next_pc[NSHIFT-1:0];
   assign prefetch_idle    = (state_q == S_IDLE);
   assign tx_command_valid = (state_q == S_REQ);
   assign tx_addr          = tx_addr_q;

   // Fetch state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Fetch next-state: acceptance beats a simultaneous withdraw request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_req) state_d = S_REQ;
         S_REQ: begin
            if (accept)        state_d = S_RECV;
            else if (withdraw) state_d = S_IDLE;
         end
         S_RECV: if (last_beat) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request address is frozen when the request is raised so it stays stable while pending.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       tx_addr_q <= '0;
      else if (start_req) tx_addr_q <= fetch_pc;
   end

   // Fetch PC: jump target shifts in serially; otherwise advances once per accepted read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      fetch_pc <= RESET_PC;
      else if (write_pc) fetch_pc <= {pc_data_in, fetch_pc[W-1:NSHIFT]};
      else if (accept)   fetch_pc <= fetch_pc + WORD_STEP;
   end

   // Architectural next-PC: jump shift, then scheduler rotation, then word consumption.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         next_pc <= RESET_PC;
      else if (write_pc)    next_pc <= {pc_data_in, next_pc[W-1:NSHIFT]};
      else if (ext_pc_next) next_pc <= {next_pc[NSHIFT-1:0], next_pc[W-1:NSHIFT]};
      else if (pc_inc)      next_pc <= next_pc + WORD_STEP;
   end

   // Word buffer fills from RX during RECV and drains toward the decoder as imm chunks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      word_buf <= '0;
      else if (rx_beat)  word_buf <= {rx_pins, word_buf[W-1:NSHIFT]};
      else if (imm_step) word_buf <= {{NSHIFT{1'b0}}, word_buf[W-1:NSHIFT]};
   end

   // Buffer validity: a word fetched across a jump is dropped instead of presented.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 buf_valid <= 1'b0;
      else if (write_pc)            buf_valid <= 1'b0;
      else if (last_beat)           buf_valid <= ~discard;
      else if (transfer | imm_last) buf_valid <= 1'b0;
   end

   // Discard marks an in-flight read made stale by a jump; cleared when that read completes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                            discard <= 1'b0;
      else if (last_beat)                                      discard <= 1'b0;
      else if (write_pc && ((state_q == S_RECV) || accept))    discard <= 1'b1;
   end

   // Beat counter restarts with every accepted read and wraps after the last beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     beat_cnt <= '0;
      else if (accept)  beat_cnt <= '0;
      else if (rx_beat) beat_cnt <= beat_cnt + 1'b1;
   end

   // Imm chunk counter wraps on the final chunk; a jump restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      imm_cnt <= '0;
      else if (write_pc) imm_cnt <= '0;
      else if (imm_step) imm_cnt <= imm_cnt + 1'b1;
   end

   // Instruction slot: refilled in the same edge the decoder retires, so no valid gap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
      end else if (transfer) begin
         inst_q       <= word_buf;
         inst_valid_q <= 1'b1;
      end else if (inst_done) begin
         inst_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_prefetcher.sv
// tb/tb_inst_prefetcher.sv - directed testbench for inst_prefetcher
module tb_inst_prefetcher;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        inst_valid;
   logic [15:0] inst;
   logic        inst_done = 1'b0;
   logic        load_imm16 = 1'b0;
   logic        imm16_loaded;
   logic [1:0]  imm_data_out;
   logic        next_imm_data = 1'b0;
   logic        block_prefetch = 1'b0;
   logic        reserve_tx = 1'b0;
   logic        write_pc = 1'b0;
   logic [1:0]  pc_data_in = 2'd0;
   logic        ext_pc_next = 1'b0;
   logic [1:0]  pc_data_out;
   logic        prefetch_idle;
   logic        tx_command_valid;
   logic [15:0] tx_addr;
   logic        tx_command_started = 1'b0;
   logic        rx_data_valid = 1'b0;
   logic [1:0]  rx_pins = 2'd0;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0]  exp_imm [8] = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
   logic [1:0]  exp_rot [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
   logic [1:0]  jump_chunks [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
   logic [1:0]  a5c3_chunks [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};

   inst_prefetcher #(.REG_BITS(8), .NSHIFT(2), .RESET_PC(16'h0000)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .inst_valid         (inst_valid),
      .inst               (inst),
      .inst_done          (inst_done),
      .load_imm16         (load_imm16),
      .imm16_loaded       (imm16_loaded),
      .imm_data_out       (imm_data_out),
      .next_imm_data      (next_imm_data),
      .block_prefetch     (block_prefetch),
      .reserve_tx         (reserve_tx),
      .write_pc           (write_pc),
      .pc_data_in         (pc_data_in),
      .ext_pc_next        (ext_pc_next),
      .pc_data_out        (pc_data_out),
      .prefetch_idle      (prefetch_idle),
      .tx_command_valid   (tx_command_valid),
      .tx_addr            (tx_addr),
      .tx_command_started (tx_command_started),
      .rx_data_valid      (rx_data_valid),
      .rx_pins            (rx_pins)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_req(input string name);
      int n = 0;
      while (!tx_command_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (tx_command_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_req_timeout: got tx_command_valid=%b want 1", name, tx_command_valid);
      end
   endtask

   task automatic serve(input logic [15:0] exp_addr, input logic [15:0] word, input string name);
      wait_req(name);
      vectors++;
      if (tx_addr !== exp_addr) begin
         miscompares++;
         $display("FAIL %s_tx_addr: got %h want %h", name, tx_addr, exp_addr);
      end
      tx_command_started = 1'b1;
      @(negedge clk);
      tx_command_started = 1'b0;
      vectors++;
      if (tx_command_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_valid_drop: got %b want 0", name, tx_command_valid);
      end
      for (int i = 0; i < 8; i++) begin
         rx_data_valid = 1'b1;
         rx_pins = word[2*i +: 2];
         @(negedge clk);
      end
      rx_data_valid = 1'b0;
   endtask

   task automatic read_next_pc(output logic [15:0] v);
      for (int i = 0; i < 8; i++) begin
         v[2*i +: 2] = pc_data_out;
         ext_pc_next = 1'b1;
         @(negedge clk);
      end
      ext_pc_next = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      vectors++;
      if ({inst_valid, imm16_loaded, tx_command_valid, prefetch_idle} !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0001",
                  {inst_valid, imm16_loaded, tx_command_valid, prefetch_idle});
      end
      vectors++;
      if ({inst, tx_addr, pc_data_out} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_values: got inst=%h tx_addr=%h pc_out=%h want 0", inst, tx_addr, pc_data_out);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_first_fetch;
      logic [15:0] npc;
      serve(16'h0000, 16'h8123, "first");
      vectors++;
      if ({inst_valid, prefetch_idle} !== 2'b01) begin
         miscompares++;
         $display("FAIL first_after_last_beat: got valid=%b idle=%b want 0 1", inst_valid, prefetch_idle);
      end
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h8123) begin
         miscompares++;
         $display("FAIL first_inst: got %b/%h want 1/8123", inst_valid, inst);
      end
      read_next_pc(npc);
      vectors++;
      if (npc !== 16'h0002) begin
         miscompares++;
         $display("FAIL first_next_pc: got %h want 0002", npc);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] npc;
      serve(16'h0002, 16'h1111, "b2b1");
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h8123) begin
         miscompares++;
         $display("FAIL b2b_slot_held: got %b/%h want 1/8123", inst_valid, inst);
      end
      inst_done = 1'b1;
      @(negedge clk);
      inst_done = 1'b0;
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h1111) begin
         miscompares++;
         $display("FAIL b2b_step1: got %b/%h want 1/1111", inst_valid, inst);
      end
      serve(16'h0004, 16'h2222, "b2b2");
      @(negedge clk);
      inst_done = 1'b1;
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h2222) begin
         miscompares++;
         $display("FAIL b2b_step2: got %b/%h want 1/2222", inst_valid, inst);
      end
      @(negedge clk);
      inst_done = 1'b0;
      vectors++;
      if (inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_retire_empty: got %b want 0", inst_valid);
      end
      read_next_pc(npc);
      vectors++;
      if (npc !== 16'h0006) begin
         miscompares++;
         $display("FAIL b2b_next_pc: got %h want 0006", npc);
      end
   endtask

   task automatic test_imm16;
      logic [15:0] npc;
      load_imm16 = 1'b1;
      serve(16'h0006, 16'hBEEF, "imm");
      #1;
      vectors++;
      if (imm16_loaded !== 1'b1) begin
         miscompares++;
         $display("FAIL imm_loaded: got %b want 1", imm16_loaded);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (imm_data_out !== exp_imm[i]) begin
            miscompares++;
            $display("FAIL imm_chunk%0d: got %0d want %0d", i, imm_data_out, exp_imm[i]);
         end
         next_imm_data = 1'b1;
         @(negedge clk);
      end
      next_imm_data = 1'b0;
      vectors++;
      if (imm16_loaded !== 1'b0 || inst !== 16'h2222 || inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL imm_done: got loaded=%b inst=%h valid=%b want 0 2222 0", imm16_loaded, inst, inst_valid);
      end
      load_imm16 = 1'b0;
      read_next_pc(npc);
      vectors++;
      if (npc !== 16'h0008) begin
         miscompares++;
         $display("FAIL imm_next_pc: got %h want 0008", npc);
      end
   endtask

   task automatic test_jump_mid_recv;
      logic [15:0] npc;
      wait_req("jump");
      vectors++;
      if (tx_addr !== 16'h0008) begin
         miscompares++;
         $display("FAIL jump_pre_addr: got %h want 0008", tx_addr);
      end
      tx_command_started = 1'b1;
      @(negedge clk);
      tx_command_started = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_data_valid = 1'b1;
         rx_pins = 2'd3;
         @(negedge clk);
      end
      rx_data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         write_pc = 1'b1;
         pc_data_in = jump_chunks[i];
         @(negedge clk);
      end
      write_pc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_data_valid = 1'b1;
         rx_pins = 2'd3;
         @(negedge clk);
      end
      rx_data_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL jump_discard: got inst_valid=%b want 0", inst_valid);
      end
      vectors++;
      if (tx_command_valid !== 1'b1 || tx_addr !== 16'h1234) begin
         miscompares++;
         $display("FAIL jump_tx_addr: got %b/%h want 1/1234", tx_command_valid, tx_addr);
      end
      read_next_pc(npc);
      vectors++;
      if (npc !== 16'h1234) begin
         miscompares++;
         $display("FAIL jump_next_pc: got %h want 1234", npc);
      end
   endtask

   task automatic test_block_prefetch;
      wait_req("block");
      block_prefetch = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx_command_valid !== 1'b0 || prefetch_idle !== 1'b1) begin
         miscompares++;
         $display("FAIL block_withdraw: got valid=%b idle=%b want 0 1", tx_command_valid, prefetch_idle);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (tx_command_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL block_hold: got %b want 0", tx_command_valid);
      end
      block_prefetch = 1'b0;
      serve(16'h1234, 16'h4321, "reissue");
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h4321) begin
         miscompares++;
         $display("FAIL reissue_inst: got %b/%h want 1/4321", inst_valid, inst);
      end
   endtask

   task automatic test_ext_rotate;
      logic [15:0] npc;
      for (int i = 0; i < 8; i++) begin
         write_pc = 1'b1;
         pc_data_in = a5c3_chunks[i];
         @(negedge clk);
      end
      write_pc = 1'b0;
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h4321) begin
         miscompares++;
         $display("FAIL wpc_inst_untouched: got %b/%h want 1/4321", inst_valid, inst);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (pc_data_out !== exp_rot[i]) begin
            miscompares++;
            $display("FAIL rot_chunk%0d: got %0d want %0d", i, pc_data_out, exp_rot[i]);
         end
         ext_pc_next = 1'b1;
         @(negedge clk);
      end
      ext_pc_next = 1'b0;
      read_next_pc(npc);
      vectors++;
      if (npc !== 16'hA5C3) begin
         miscompares++;
         $display("FAIL rot_restored: got %h want a5c3", npc);
      end
   endtask

   task automatic test_reset_abort;
      logic [15:0] npc;
      wait_req("abort");
      vectors++;
      if (tx_addr !== 16'hA5C3) begin
         miscompares++;
         $display("FAIL abort_pre_addr: got %h want a5c3", tx_addr);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({tx_command_valid, prefetch_idle, inst_valid} !== 3'b010 || tx_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL abort_reset: got valid=%b idle=%b inst_valid=%b addr=%h want 0 1 0 0000",
                  tx_command_valid, prefetch_idle, inst_valid, tx_addr);
      end
      @(negedge clk);
      reset_n = 1'b1;
      block_prefetch = 1'b1;
      read_next_pc(npc);
      block_prefetch = 1'b0;
      vectors++;
      if (npc !== 16'h0000) begin
         miscompares++;
         $display("FAIL abort_next_pc: got %h want 0000", npc);
      end
   endtask

   initial begin
      test_reset;
      test_first_fetch;
      test_back_to_back;
      test_imm16;
      test_jump_mid_recv;
      test_block_prefetch;
      test_ext_rotate;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
